// File: rtl/decode_stage_pipe_if.sv
// Handshake and write-back bundle between fetch, decode, write-back and execute.
interface decode_stage_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic            out_funct7b5;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_pc, in_instr, flush, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_rs1_data, out_rs2_data, out_imm, out_opcode, out_funct3,
           out_funct7b5, out_illegal
  );

  modport master (
    output in_valid, in_pc, in_instr, flush, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_rs1_data, out_rs2_data, out_imm, out_opcode, out_funct3,
           out_funct7b5, out_illegal
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// Registered decode stage: field decode, register-file read with optional
// write-back bypass, immediate generation and an ID/EX register with
// valid/ready handshake, flush and stall-time operand refresh.
module decode_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input logic                clk,
  input logic                rst_n,
  decode_stage_pipe_if.slave io_bus
);

  localparam logic [5:0] LP_NREGS  = 6'(NREGS);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Array is always 32 deep so a 5-bit index never overruns it; entries at
  // or above NREGS are never written and never read.
  logic [XLEN-1:0] r_regs [32];

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic            r_funct7b5;
  logic            r_illegal;

  logic [31:0]     w_instr;
  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic            w_rs1_ok;
  logic            w_rs2_ok;
  logic            w_wb_hit;
  logic            w_in_ready;
  logic            w_capture;
  logic            w_stall;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_op_legal;
  logic            w_illegal;

  assign w_instr  = io_bus.in_instr;
  assign w_opcode = w_instr[6:0];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];
  assign w_rd     = w_instr[11:7];

  assign w_rs1_ok = (w_rs1 != 5'd0) && ({1'b0, w_rs1} < LP_NREGS);
  assign w_rs2_ok = (w_rs2 != 5'd0) && ({1'b0, w_rs2} < LP_NREGS);
  assign w_wb_hit = io_bus.wb_en && (io_bus.wb_rd != 5'd0) &&
                    ({1'b0, io_bus.wb_rd} < LP_NREGS);

  assign w_in_ready = !io_bus.flush && (!r_valid || io_bus.out_ready);
  assign w_capture  = io_bus.in_valid && w_in_ready;
  assign w_stall    = r_valid && !io_bus.out_ready;

  // Register-file write port; x0 and out-of-range indices are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_hit) begin
      r_regs[io_bus.wb_rd] <= io_bus.wb_data;
    end
  end

  // Operand read ports with optional same-cycle write-back forwarding.
  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if (w_rs1_ok) begin
      if ((BYPASS != 0) && w_wb_hit && (io_bus.wb_rd == w_rs1)) begin
        w_rs1_data = io_bus.wb_data;
      end else begin
        w_rs1_data = r_regs[w_rs1];
      end
    end
    if (w_rs2_ok) begin
      if ((BYPASS != 0) && w_wb_hit && (io_bus.wb_rd == w_rs2)) begin
        w_rs2_data = io_bus.wb_data;
      end else begin
        w_rs2_data = r_regs[w_rs2];
      end
    end
  end

  // Immediate selection and opcode legality.
  always_comb begin
    w_imm32    = '0;
    w_op_legal = 1'b0;
    case (w_opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        w_imm32    = {{20{w_instr[31]}}, w_instr[31:20]};
        w_op_legal = 1'b1;
      end
      OP_STORE: begin
        w_imm32    = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
        w_op_legal = 1'b1;
      end
      OP_BRANCH: begin
        w_imm32    = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                      w_instr[30:25], w_instr[11:8], 1'b0};
        w_op_legal = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_imm32    = {w_instr[31:12], 12'b0};
        w_op_legal = 1'b1;
      end
      OP_JAL: begin
        w_imm32    = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                      w_instr[20], w_instr[30:21], 1'b0};
        w_op_legal = 1'b1;
      end
      OP_REG, OP_SYSTEM, OP_FENCE: begin
        w_imm32    = '0;
        w_op_legal = 1'b1;
      end
      default: begin
        w_imm32    = '0;
        w_op_legal = 1'b0;
      end
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  // Register fields are checked even when the format reuses them as
  // immediate bits; execute decides what to do with the trap.
  assign w_illegal = !w_op_legal ||
                     ({1'b0, w_rs1} >= LP_NREGS) ||
                     ({1'b0, w_rs2} >= LP_NREGS) ||
                     ({1'b0, w_rd}  >= LP_NREGS);

  // ID/EX register: flush wins, then capture, then stall hold with
  // write-back refresh of held operands, otherwise drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (io_bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid    <= 1'b1;
      r_pc       <= io_bus.in_pc;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_imm      <= w_imm;
      r_opcode   <= w_opcode;
      r_funct3   <= w_instr[14:12];
      r_funct7b5 <= w_instr[30];
      r_illegal  <= w_illegal;
    end else if (w_stall) begin
      if (w_wb_hit && (io_bus.wb_rd == r_rs1)) begin
        r_rs1_data <= io_bus.wb_data;
      end
      if (w_wb_hit && (io_bus.wb_rd == r_rs2)) begin
        r_rs2_data <= io_bus.wb_data;
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign io_bus.in_ready     = w_in_ready;
  assign io_bus.out_valid    = r_valid;
  assign io_bus.out_pc       = r_pc;
  assign io_bus.out_rs1      = r_rs1;
  assign io_bus.out_rs2      = r_rs2;
  assign io_bus.out_rd       = r_rd;
  assign io_bus.out_rs1_data = r_rs1_data;
  assign io_bus.out_rs2_data = r_rs2_data;
  assign io_bus.out_imm      = r_imm;
  assign io_bus.out_opcode   = r_opcode;
  assign io_bus.out_funct3   = r_funct3;
  assign io_bus.out_funct7b5 = r_funct7b5;
  assign io_bus.out_illegal  = r_illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench: three decode stages (default, no bypass, RV32E) fed the
// same stimulus, checked against hand-computed values.
module tb_decode_stage_pipe;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  decode_stage_pipe_if #(.XLEN(32)) if_a ();
  decode_stage_pipe_if #(.XLEN(32)) if_b ();
  decode_stage_pipe_if #(.XLEN(32)) if_c ();

  decode_stage_pipe #(.XLEN(32), .NREGS(32), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .io_bus(if_a)
  );
  decode_stage_pipe #(.XLEN(32), .NREGS(32), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .io_bus(if_b)
  );
  decode_stage_pipe #(.XLEN(32), .NREGS(16), .BYPASS(1)) u_dut_e (
    .clk(clk), .rst_n(rst_n), .io_bus(if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act,
                           input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc,
                        input logic [31:0] instr);
    if_a.in_valid = v; if_a.in_pc = pc; if_a.in_instr = instr;
    if_b.in_valid = v; if_b.in_pc = pc; if_b.in_instr = instr;
    if_c.in_valid = v; if_c.in_pc = pc; if_c.in_instr = instr;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] rd,
                        input logic [31:0] data);
    if_a.wb_en = en; if_a.wb_rd = rd; if_a.wb_data = data;
    if_b.wb_en = en; if_b.wb_rd = rd; if_b.wb_data = data;
    if_c.wb_en = en; if_c.wb_rd = rd; if_c.wb_data = data;
  endtask

  task automatic set_ctl(input logic fl, input logic ordy);
    if_a.flush = fl; if_a.out_ready = ordy;
    if_b.flush = fl; if_b.out_ready = ordy;
    if_c.flush = fl; if_c.out_ready = ordy;
  endtask

  logic [31:0] tv_instr [10];
  logic [31:0] tv_imm   [10];
  logic        tv_ill_a [10];
  logic        tv_ill_e [10];

  initial begin
    // sw x2,-4(x1); beq -8; jal +2048; opcode 0x7F; addi x20,x0,0;
    // lui x5,0x12345; lui x1,0x80000; ecall; jalr x0,0(x1); addi x5,x0,-1
    tv_instr = '{32'hFE20AE23, 32'hFE000CE3, 32'h0010006F, 32'h0000007F,
                 32'h00000A13, 32'h123452B7, 32'h800000B7, 32'h00000073,
                 32'h00008067, 32'hFFF00293};
    tv_imm   = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800, 32'h00000000,
                 32'h00000000, 32'h12345000, 32'h80000000, 32'h00000000,
                 32'h00000000, 32'hFFFFFFFF};
    tv_ill_a = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // RV32E: sw rd-field 28, beq rd-field 25, x20 and rs2-field 31 trap
    tv_ill_e = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    set_in(1'b0, 32'h0, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);
    set_ctl(1'b0, 1'b1);
    tick();
    tick();
    check_val("rst_valid", 64'(if_a.out_valid), 64'd0);
    check_val("rst_pc", 64'(if_a.out_pc), 64'd0);
    check_val("rst_rs1_data", 64'(if_a.out_rs1_data), 64'd0);
    check_val("rst_imm", 64'(if_a.out_imm), 64'd0);
    check_val("rst_in_ready", 64'(if_a.in_ready), 64'd1);
    rst_n = 1'b1;

    // write x5 then addi x6,x5,-1
    set_wb(1'b1, 5'd5, 32'h1234);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    set_in(1'b1, 32'h100, 32'hFFF28313);
    tick();
    set_in(1'b0, 32'h0, 32'h0);
    check_val("t1_valid", 64'(if_a.out_valid), 64'd1);
    check_val("t1_pc", 64'(if_a.out_pc), 64'h100);
    check_val("t1_rs1", 64'(if_a.out_rs1), 64'd5);
    check_val("t1_rs1_data", 64'(if_a.out_rs1_data), 64'h1234);
    check_val("t1_imm", 64'(if_a.out_imm), 64'hFFFFFFFF);
    check_val("t1_rd", 64'(if_a.out_rd), 64'd6);
    check_val("t1_illegal", 64'(if_a.out_illegal), 64'd0);
    check_val("t1_opcode", 64'(if_a.out_opcode), 64'h13);
    check_val("t1_nb_rs1_data", 64'(if_b.out_rs1_data), 64'h1234);
    tick();
    check_val("t1_drain", 64'(if_a.out_valid), 64'd0);

    // x0 protection: write x0, then write x0 again while reading it
    set_wb(1'b1, 5'd0, 32'hDEAD);
    tick();
    set_in(1'b1, 32'h104, 32'h00000133);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    set_in(1'b0, 32'h0, 32'h0);
    check_val("t2_rs1_data", 64'(if_a.out_rs1_data), 64'd0);
    check_val("t2_rs2_data", 64'(if_a.out_rs2_data), 64'd0);
    check_val("t2_nb_rs1_data", 64'(if_b.out_rs1_data), 64'd0);

    // bypass: x7=0x11, then same-cycle x7=0xAA with add x1,x7,x7
    set_wb(1'b1, 5'd7, 32'h11);
    tick();
    set_wb(1'b1, 5'd7, 32'hAA);
    set_in(1'b1, 32'h108, 32'h007380B3);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    set_in(1'b0, 32'h0, 32'h0);
    check_val("t3_byp_rs1", 64'(if_a.out_rs1_data), 64'hAA);
    check_val("t3_byp_rs2", 64'(if_a.out_rs2_data), 64'hAA);
    check_val("t3_nobyp_rs1", 64'(if_b.out_rs1_data), 64'h11);
    check_val("t3_nobyp_rs2", 64'(if_b.out_rs2_data), 64'h11);
    check_val("t3_imm", 64'(if_a.out_imm), 64'd0);
    check_val("t3_illegal", 64'(if_a.out_illegal), 64'd0);

    // stall refresh: x8=0x80, x9=0x90, capture sub x3,x8,x9 and stall
    set_wb(1'b1, 5'd8, 32'h80);
    tick();
    set_wb(1'b1, 5'd9, 32'h90);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    set_ctl(1'b0, 1'b0);
    set_in(1'b1, 32'h200, 32'h409401B3);
    tick();
    set_in(1'b1, 32'h204, 32'h00000133);
    #1;
    check_val("t4_c1_in_ready", 64'(if_a.in_ready), 64'd0);
    check_val("t4_c1_valid", 64'(if_a.out_valid), 64'd1);
    check_val("t4_c1_rs1_data", 64'(if_a.out_rs1_data), 64'h80);
    check_val("t4_c1_rs2_data", 64'(if_a.out_rs2_data), 64'h90);
    check_val("t4_c1_f7b5", 64'(if_a.out_funct7b5), 64'd1);
    check_val("t4_c1_rd", 64'(if_a.out_rd), 64'd3);
    tick();
    set_wb(1'b1, 5'd9, 32'h55);
    #1;
    check_val("t4_c2_in_ready", 64'(if_a.in_ready), 64'd0);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    check_val("t4_c3_rs2_data", 64'(if_a.out_rs2_data), 64'h55);
    check_val("t4_c3_nb_rs2_data", 64'(if_b.out_rs2_data), 64'h55);
    check_val("t4_c3_rs1_data", 64'(if_a.out_rs1_data), 64'h80);
    check_val("t4_c3_pc", 64'(if_a.out_pc), 64'h200);
    check_val("t4_c3_rd", 64'(if_a.out_rd), 64'd3);
    check_val("t4_c3_rs2", 64'(if_a.out_rs2), 64'd9);
    check_val("t4_c3_valid", 64'(if_a.out_valid), 64'd1);
    check_val("t4_c3_in_ready", 64'(if_a.in_ready), 64'd0);
    tick();
    check_val("t4_c4_rs2_data", 64'(if_a.out_rs2_data), 64'h55);
    check_val("t4_c4_pc", 64'(if_a.out_pc), 64'h200);

    // flush while stalled with an incoming instruction
    set_ctl(1'b1, 1'b0);
    #1;
    check_val("t5_in_ready", 64'(if_a.in_ready), 64'd0);
    tick();
    set_ctl(1'b0, 1'b0);
    set_in(1'b0, 32'h0, 32'h0);
    check_val("t5_valid", 64'(if_a.out_valid), 64'd0);
    check_val("t5_not_captured", 64'(if_a.out_pc == 32'h204), 64'd0);
    tick();
    check_val("t5_valid_after", 64'(if_a.out_valid), 64'd0);
    set_ctl(1'b0, 1'b1);

    // reset mid-operation clears the pipe and the register file
    set_in(1'b1, 32'h300, 32'h007380B3);
    tick();
    set_in(1'b0, 32'h0, 32'h0);
    check_val("rm_pre_rs1_data", 64'(if_a.out_rs1_data), 64'hAA);
    rst_n = 1'b0;
    #1;
    check_val("rm_valid", 64'(if_a.out_valid), 64'd0);
    check_val("rm_pc", 64'(if_a.out_pc), 64'd0);
    tick();
    rst_n = 1'b1;
    set_in(1'b1, 32'h304, 32'h007380B3);
    tick();
    set_in(1'b0, 32'h0, 32'h0);
    check_val("rm_post_valid", 64'(if_a.out_valid), 64'd1);
    check_val("rm_post_rs1_data", 64'(if_a.out_rs1_data), 64'd0);

    // immediates and illegal detection, back to back
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 32'h400 + 32'(i * 4), tv_instr[i]);
      tick();
      check_val($sformatf("imm[%0d]", i), 64'(if_a.out_imm), 64'(tv_imm[i]));
      check_val($sformatf("ill[%0d]", i), 64'(if_a.out_illegal),
                64'(tv_ill_a[i]));
      check_val($sformatf("ill_e[%0d]", i), 64'(if_c.out_illegal),
                64'(tv_ill_e[i]));
      check_val($sformatf("pc[%0d]", i), 64'(if_a.out_pc),
                64'(32'h400 + 32'(i * 4)));
    end
    set_in(1'b0, 32'h0, 32'h0);
    tick();
    check_val("end_drain", 64'(if_a.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
